deq_beat_serializer: RTL

//  - Drain side of a one-entry FIFO. Pulls 128-bit words from an upstream deq/first interface.
//  - Emits each word as BEATS narrower beats into a downstream enq interface, LSB beat first.
//  - Sits between the echo datapath FIFO output and narrow indication/transport channels.

---
 rtl/deq_beat_serializer_if.sv | 25 ++
 rtl/deq_beat_serializer.sv | 82 ++++++++
 2 files changed

// File: rtl/deq_beat_serializer_if.sv
// rtl/deq_beat_serializer_if.sv - upstream deq/first and downstream enq handshake bundle
// master drives the upstream word and both ready inputs; slave is the serializer.
interface deq_beat_serializer_if #(
    parameter int WIDTH = 128,
    parameter int BEAT  = 32
);
    logic [WIDTH-1:0] in_first;
    logic             in_first_rdy;
    logic             in_deq_rdy;
    logic             in_deq_ena;
    logic             out_enq_ena;
    logic [BEAT-1:0]  out_enq_v;
    logic             out_enq_last;
    logic             out_enq_rdy;

    modport master (
        output in_first, in_first_rdy, in_deq_rdy, out_enq_rdy,
        input  in_deq_ena, out_enq_ena, out_enq_v, out_enq_last
    );

    modport slave (
        input  in_first, in_first_rdy, in_deq_rdy, out_enq_rdy,
        output in_deq_ena, out_enq_ena, out_enq_v, out_enq_last
    );
endinterface

// File: rtl/deq_beat_serializer.sv
// rtl/deq_beat_serializer.sv - drains one wide word at a time and emits it as LSB-first beats
// Optional SERIALIZER_BACK2BACK_EN: reload on the last beat for zero-bubble word streaming.
module deq_beat_serializer #(
    parameter int WIDTH = 128,
    parameter int BEAT  = 32,
    parameter int BEATS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    deq_beat_serializer_if.slave   ser
);
    localparam int CW = $clog2(BEATS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             deq_ena, enq_ena, cnt_last;

    assign cnt_last = (cnt_q == CW'(BEATS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Handshakes are suppressed while reset is held so nothing is consumed or emitted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        deq_ena = 1'b0;
        enq_ena = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    deq_ena = ser.in_first_rdy & ser.in_deq_rdy;
                    if (deq_ena) begin
                        shreg_d = ser.in_first;
                        cnt_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    enq_ena = ser.out_enq_rdy;
                    if (enq_ena) begin
                        if (cnt_last) begin
                            cnt_d   = '0;
`ifdef SERIALIZER_BACK2BACK_EN
                            deq_ena = ser.in_first_rdy & ser.in_deq_rdy;
                            if (deq_ena) begin
                                shreg_d = ser.in_first;
                            end else begin
                                state_d = IDLE;
                            end
`else
                            state_d = IDLE;
`endif
                        end else begin
                            shreg_d = shreg_q >> BEAT;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ser.in_deq_ena   = deq_ena;
    assign ser.out_enq_ena  = enq_ena;
    assign ser.out_enq_v    = (state_q == SEND && !rst_i) ? shreg_q[BEAT-1:0] : '0;
    assign ser.out_enq_last = (state_q == SEND && !rst_i) ? cnt_last : 1'b0;
endmodule
